int_to_real_cvt: RTL and testbench
==================================

Name: int_to_real_cvt

Overview:
- Sequential integer-to-IEEE-754-double converter.
- It is the inverse of the real-to-integer truncation and rounding paths exercised by the math regression tests.
- Accepts one signed or two's-complement integer per handshake and returns the 64-bit binary64 encoding, rounded to nearest with ties to even.
- Used by datapath tests and as a golden reference for $itor / real-assignment checks.

Parameters:
- WIDTH, 64, input integer width; legal range 2..64.
- SIGNED, 1, 1 treats in_data as two's complement, 0 as unsigned.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  converter can accept an input.
- in_data  input  WIDTH  integer to convert.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  64  binary64 result: sign[63], exponent[62:52], fraction[51:0].

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=S_IDLE, in_ready=0 during the reset cycle and 1 afterwards, out_valid=0, out_data=0.
- An operation in flight when rst is asserted is discarded; no output is produced for it.
- FSM states:
  - S_IDLE: in_ready=1. On in_valid&in_ready, capture sign and magnitude, go to S_NORM.
  - S_NORM: run LZC on the magnitude, left-shift so the MSB sits at bit 63, set exponent = 1023+63-lzc, go to S_ROUND.
  - S_ROUND: round 64-bit normalized mantissa to 53 bits; go to S_OUT.
  - S_OUT: out_valid=1, out_data held stable. On out_ready, go to S_IDLE.
- Latency: out_valid rises exactly 3 cycles after the accepting edge.
- in_ready=0 in every state except S_IDLE, so there is one operation in flight and throughput is at most one per 4 cycles.
- Back-to-back operation: the out_ready handshake moves to S_IDLE; the next input is accepted the following cycle, not the same cycle.
- Sign and magnitude:
  - SIGNED=1: sign=in_data[WIDTH-1]; magnitude = two's-complement absolute value in WIDTH+1 bits, so the most-negative value is exact (e.g. -2^63 has magnitude 2^63).
  - SIGNED=0: sign=0.
- Zero input: out_data=64'h0 (+0.0, never -0.0). Exponent and fraction are forced to 0 and LZC is bypassed.
- Rounding:
  - Guard = bit 10 of the normalized value; sticky = OR of bits 9:0.
  - Increment if guard & (sticky | lsb).
  - Mantissa carry-out increments the exponent and clears the fraction.
  - No overflow is possible because |x| < 2^64 < DBL_MAX.
- WIDTH<=53: rounding never changes the result (all values are exact).
- out_data changes only on the transition into S_OUT.
- in_data is sampled only at the accepting edge; changes to it at other times are ignored.

Optional Feature:
- Macro: INT_TO_REAL_INEXACT_EN.
- Defined: adds output port out_inexact (1 bit), valid with out_valid, equal to guard|sticky of the rounded result; reset value 0.
- Undefined: port absent; all other behaviour identical.

Decomposition:
- Package int_to_real_pkg holds:
  - state enum (S_IDLE, S_NORM, S_ROUND, S_OUT), 2 bits;
  - constants DBL_BIAS=1023, DBL_EXP_W=11, DBL_FRAC_W=52, DBL_W=64.
- One sub-module, int_to_real_lzc: combinational 64-bit leading-zero count with a 7-bit output, 64 for an all-zero input.

Test Plan:
- SIGNED=1, WIDTH=64, in_data=123 -> out_data=64'h405EC00000000000, out_valid 3 cycles after accept.
- in_data=-1 -> 64'hBFF0000000000000; in_data=0 -> 64'h0000000000000000; in_data=-2^63 -> 64'hC3E0000000000000.
- Rounding:
  - 2^53+1 -> 64'h4340000000000000 (tie to even down);
  - 2^53+3 -> 64'h4340000000000002 (tie to even up);
  - with INT_TO_REAL_INEXACT_EN, out_inexact=1 for both and 0 for 123.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0 throughout, no second input accepted.
- Reset mid-operation: assert rst in S_NORM -> next cycle out_valid=0, no stale output appears; a fresh in_data=5 converts to 64'h4014000000000000.
- SIGNED=0, WIDTH=8, in_data=8'hFF -> 64'h406FE00000000000 (255.0).

Source files
------------

// File: rtl/int_to_real_pkg.sv
// Shared definitions for the integer-to-binary64 converter.
//   state_t   : converter FSM states
//   DBL_*     : binary64 field widths and exponent bias
//   pack_dbl  : assembles sign/exponent/fraction into a 64-bit word
package int_to_real_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam int DBL_BIAS   = 1023;
    localparam int DBL_EXP_W  = 11;
    localparam int DBL_FRAC_W = 52;
    localparam int DBL_W      = 64;

    function automatic logic [DBL_W-1:0] pack_dbl(
        input logic                  sign,
        input logic [DBL_EXP_W-1:0]  exponent,
        input logic [DBL_FRAC_W-1:0] fraction
    );
        return {sign, exponent, fraction};
    endfunction

endpackage

// File: rtl/int_to_real_lzc.sv
// 64-bit leading-zero counter (purely combinational).
//   value : word to scan, bit 63 is the most significant
//   count : number of zeros above the highest set bit; 64 for an all-zero word
module int_to_real_lzc (
    input  logic [63:0] value,
    output logic [6:0]  count
);

    // seen[gi] is set when any bit at or above position gi is one. The
    // number of set positions equals 64 - lzc, so counting them gives lzc.
    logic [63:0] seen;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_seen
            assign seen[gi] = |value[63:gi];
        end
    endgenerate

    always_comb begin
        logic [6:0] ones;
        ones = 7'd0;
        for (int i = 0; i < 64; i++) begin
            ones = ones + 7'(seen[i]);
        end
        count = 7'd64 - ones;
    end

endmodule

// File: rtl/int_to_real_cvt.sv
// Sequential integer to IEEE-754 binary64 converter, round to nearest even.
// One operation in flight: IDLE (accept) -> NORM -> ROUND -> OUT (hold until
// out_ready). out_valid is high in the third cycle after the accept cycle.
//
// Parameters:
//   WIDTH  : input width, 2..64
//   SIGNED : 1 = in_data is two's complement, 0 = unsigned
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake, in_data sampled on acceptance
//   in_data [WIDTH-1:0]  : integer to convert
//   out_valid/out_ready  : output handshake, out_data held while waiting
//   out_data [63:0]      : binary64 result
//   out_inexact          : only when INT_TO_REAL_INEXACT_EN is defined;
//                          1 when rounding discarded nonzero bits
module int_to_real_cvt
    import int_to_real_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DBL_W-1:0] out_data
`ifdef INT_TO_REAL_INEXACT_EN
    ,
    output logic             out_inexact
`endif
);

    localparam logic [DBL_EXP_W-1:0] EXP_TOP = DBL_EXP_W'(DBL_BIAS + DBL_W - 1);

    state_t state_reg, state_next;

    logic                 sign_reg;
    logic [63:0]          mag_reg;
    logic [63:0]          norm_reg;
    logic [DBL_EXP_W-1:0] exp_reg;
    logic [DBL_W-1:0]     out_data_reg;

    // ---------------- capture: sign and magnitude ----------------
    logic        in_sign;
    logic [63:0] in_ext;
    logic [63:0] in_mag;

    always_comb begin
        in_sign = SIGNED ? in_data[WIDTH-1] : 1'b0;
        if (SIGNED) begin
            in_ext = 64'($signed(in_data));
        end else begin
            in_ext = 64'(in_data);
        end
        // Negating modulo 2^64 and reading the result as unsigned makes the
        // most-negative value exact (-2^63 -> 2^63).
        in_mag = in_sign ? (~in_ext + 64'd1) : in_ext;
    end

    // ---------------- normalise ----------------
    logic [6:0]           lzc_cnt;
    logic [63:0]          norm_shift;
    logic [DBL_EXP_W-1:0] exp_norm;

    int_to_real_lzc u_lzc (
        .value (mag_reg),
        .count (lzc_cnt)
    );

    always_comb begin
        // A zero magnitude reports 64; the shift and exponent are bypassed so
        // the encoding collapses to +0.0.
        if (lzc_cnt[6]) begin
            norm_shift = 64'd0;
            exp_norm   = '0;
        end else begin
            norm_shift = mag_reg << lzc_cnt[5:0];
            exp_norm   = EXP_TOP - DBL_EXP_W'(lzc_cnt);
        end
    end

    // ---------------- round ----------------
    // norm_reg[63] is the hidden one (clear only for a zero input),
    // [62:11] the fraction, [10] guard, [9:0] sticky.
    logic                        guard_bit;
    logic                        sticky_bit;
    logic                        round_up;
    logic [DBL_EXP_W+DBL_FRAC_W-1:0] body_rnd;
    logic [DBL_W-1:0]            result;

    always_comb begin
        guard_bit  = norm_reg[10];
        sticky_bit = |norm_reg[9:0];
        round_up   = guard_bit & (sticky_bit | norm_reg[11]);
        // Adding across the concatenated exponent/fraction lets a fraction
        // carry-out bump the exponent and leave a zero fraction for free.
        body_rnd   = {exp_reg, norm_reg[62:11]} + (DBL_EXP_W+DBL_FRAC_W)'(round_up);
        if (norm_reg[63]) begin
            result = pack_dbl(sign_reg, body_rnd[DBL_EXP_W+DBL_FRAC_W-1:DBL_FRAC_W],
                              body_rnd[DBL_FRAC_W-1:0]);
        end else begin
            result = '0;
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (in_valid) state_next = S_NORM;
            S_NORM:  state_next = S_ROUND;
            S_ROUND: state_next = S_OUT;
            S_OUT:   if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            sign_reg     <= 1'b0;
            mag_reg      <= '0;
            norm_reg     <= '0;
            exp_reg      <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_reg <= in_sign;
                        mag_reg  <= in_mag;
                    end
                end
                S_NORM: begin
                    norm_reg <= norm_shift;
                    exp_reg  <= exp_norm;
                end
                S_ROUND: begin
                    out_data_reg <= result;
                end
                default: ;
            endcase
        end
    end

`ifdef INT_TO_REAL_INEXACT_EN
    logic inexact_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            inexact_reg <= 1'b0;
        end else if (state_reg == S_ROUND) begin
            inexact_reg <= guard_bit | sticky_bit;
        end
    end

    assign out_inexact = inexact_reg;
`else
    // No inexact flag in this build.
`endif

    // in_ready is gated by rst so it stays low during the reset cycle itself.
    assign in_ready  = (state_reg == S_IDLE) && !rst;
    assign out_valid = (state_reg == S_OUT);
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_int_to_real_cvt.sv
// Directed bench for int_to_real_cvt: a signed 64-bit instance (a_*) and an
// unsigned 8-bit instance (b_*) sharing one clock. Inputs are driven and
// outputs sampled on the falling edge.
module tb_int_to_real_cvt;

    logic clk = 1'b0;
    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data;
    logic [63:0] b_out_data;
`ifdef INT_TO_REAL_INEXACT_EN
    logic        a_inexact, b_inexact;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    int_to_real_cvt #(.WIDTH(64), .SIGNED(1'b1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data)
`ifdef INT_TO_REAL_INEXACT_EN
        ,
        .out_inexact (a_inexact)
`endif
    );

    int_to_real_cvt #(.WIDTH(8), .SIGNED(1'b0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
`ifdef INT_TO_REAL_INEXACT_EN
        ,
        .out_inexact (b_inexact)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction on dut_a; starts and ends on a falling edge in S_IDLE.
    // hold = extra cycles with out_ready low (and a stray in_valid) in S_OUT.
    task automatic convert_a(input string tag, input logic [63:0] val,
                             input logic [63:0] exp, input logic exp_inx,
                             input int hold);
        check({tag, ".rdy"}, 64'(a_in_ready), 64'd1);
        a_in_valid = 1'b1;
        a_in_data  = val;
        @(negedge clk);                       // accept edge has passed
        a_in_valid = 1'b0;
        a_in_data  = ~val;                    // must be ignored from now on
        check({tag, ".lat1"}, 64'(a_out_valid), 64'd0);
        check({tag, ".busy"}, 64'(a_in_ready), 64'd0);
        @(negedge clk);
        check({tag, ".lat2"}, 64'(a_out_valid), 64'd0);
        @(negedge clk);
        check({tag, ".valid"}, 64'(a_out_valid), 64'd1);
        check({tag, ".data"}, a_out_data, exp);
`ifdef INT_TO_REAL_INEXACT_EN
        check({tag, ".inexact"}, 64'(a_inexact), 64'(exp_inx));
`else
        if (exp_inx === 1'bx) $display("[TB] unexpected x flag in %s", tag);
`endif
        for (int i = 0; i < hold; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 64'd999 + 64'(i);
            @(negedge clk);
            check({tag, ".hold_valid"}, 64'(a_out_valid), 64'd1);
            check({tag, ".hold_data"}, a_out_data, exp);
            check({tag, ".hold_rdy"}, 64'(a_in_ready), 64'd0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check({tag, ".done"}, 64'(a_out_valid), 64'd0);
        check({tag, ".idle"}, 64'(a_in_ready), 64'd1);
        $display("[TB] %s in=%h out=%h", tag, val, exp);
    endtask

    task automatic convert_b(input string tag, input logic [7:0] val,
                             input logic [63:0] exp);
        check({tag, ".rdy"}, 64'(b_in_ready), 64'd1);
        b_in_valid = 1'b1;
        b_in_data  = val;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_data  = ~val;
        check({tag, ".lat1"}, 64'(b_out_valid), 64'd0);
        @(negedge clk);
        check({tag, ".lat2"}, 64'(b_out_valid), 64'd0);
        @(negedge clk);
        check({tag, ".valid"}, 64'(b_out_valid), 64'd1);
        check({tag, ".data"}, b_out_data, exp);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        check({tag, ".done"}, 64'(b_out_valid), 64'd0);
        $display("[TB] %s in=%h out=%h", tag, val, exp);
    endtask

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b0;

        // Reset state, observed while rst is still high
        repeat (3) @(negedge clk);
        check("rst.in_ready", 64'(a_in_ready), 64'd0);
        check("rst.out_valid", 64'(a_out_valid), 64'd0);
        check("rst.out_data", a_out_data, 64'd0);
        check("rst.b_in_ready", 64'(b_in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.in_ready", 64'(a_in_ready), 64'd1);

        // Signed 64-bit vectors
        convert_a("s123",   64'd123,                  64'h405EC00000000000, 1'b0, 0);
        convert_a("sneg1",  64'hFFFFFFFFFFFFFFFF,     64'hBFF0000000000000, 1'b0, 0);
        convert_a("szero",  64'd0,                    64'h0000000000000000, 1'b0, 0);
        convert_a("smin",   64'h8000000000000000,     64'hC3E0000000000000, 1'b0, 0);
        convert_a("tie_dn", 64'h0020000000000001,     64'h4340000000000000, 1'b1, 0);
        convert_a("tie_up", 64'h0020000000000003,     64'h4340000000000002, 1'b1, 0);
        // 2^63-1 rounds up through a mantissa carry to exactly 2^63
        convert_a("carry",  64'h7FFFFFFFFFFFFFFF,     64'h43E0000000000000, 1'b1, 0);
        // Backpressure: 10 cycles of out_ready low with a stray in_valid
        convert_a("bp",     64'hFFFFFFFFFFFFFF85,     64'hC05EC00000000000, 1'b0, 10);
        // No second transaction may have been accepted during the hold
        repeat (4) begin
            @(negedge clk);
            check("bp.quiet", 64'(a_out_valid), 64'd0);
        end

        // Reset in S_NORM: operation dropped, no stale output
        a_in_valid = 1'b1;
        a_in_data  = 64'd77;
        @(negedge clk);
        a_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst.out_valid", 64'(a_out_valid), 64'd0);
        check("midrst.in_ready", 64'(a_in_ready), 64'd0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midrst.no_stale", 64'(a_out_valid), 64'd0);
        end
        check("midrst.out_data", a_out_data, 64'd0);
        convert_a("after_rst5", 64'd5, 64'h4014000000000000, 1'b0, 0);

        // Unsigned 8-bit vectors
        convert_b("u255", 8'hFF, 64'h406FE00000000000);
        convert_b("u128", 8'h80, 64'h4060000000000000);
        convert_b("u1",   8'h01, 64'h3FF0000000000000);
        convert_b("u0",   8'h00, 64'h0000000000000000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
